// File: rtl/soc_amp_pkg.sv
// Shared constants and types for the amplitude ramp block.
package soc_amp_pkg;

  localparam logic [3:0] ADDR_STEP = 4'h8;
  localparam logic [3:0] ADDR_CTRL = 4'h9;
  localparam logic [3:0] ADDR_BUSY = 4'hA;
  localparam logic [3:0] ADDR_DONE = 4'hB;
  localparam logic [3:0] ADDR_CUR  = 4'hC;

  localparam int unsigned CTRL_BYPASS  = 0;
  localparam int unsigned CTRL_FREEZE  = 1;
  localparam int unsigned CTRL_IRQ_EN  = 2;
  localparam int unsigned CTRL_SEL_LSB = 4;
  localparam int unsigned CTRL_SEL_MSB = 6;
  localparam int unsigned CTRL_W       = 7;

  // Writable CTRL bits; bit 3 is held at zero.
  localparam logic [CTRL_W-1:0] CTRL_MASK = 7'b111_0111;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } chan_state_e;

endpackage

// File: rtl/soc_amp_ramp_chan.sv
// One amplitude channel: TARGET/CURRENT registers and slew limiting.
module soc_amp_ramp_chan
  import soc_amp_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             target_we,
  input  logic [WIDTH-1:0] target_wdata,
  input  logic [WIDTH-1:0] step,
  input  logic             tick,
  input  logic             bypass,
  input  logic             freeze,
  output logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] current,
  output logic             busy,
  output logic             done_set
);

  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] current_q, current_d;
  logic [WIDTH-1:0] diff;
  chan_state_e      state_q, state_d;

  // Next target/current; the step always uses the registered target and step.
  always_comb begin
    target_d  = target_we ? target_wdata : target_q;
    current_d = current_q;
    diff      = '0;
    if (bypass) begin
      current_d = target_q;
    end else if (tick && !freeze) begin
      if (target_q >= current_q) begin
        diff      = target_q - current_q;
        current_d = (diff <= step) ? target_q : current_q + step;
      end else begin
        diff      = current_q - target_q;
        current_d = (diff <= step) ? target_q : current_q - step;
      end
    end
    state_d  = (current_d == target_d) ? IDLE : RAMP;
    done_set = (state_q == RAMP) && (state_d == IDLE);
  end

  // Channel registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      target_q  <= '0;
      current_q <= '0;
      state_q   <= IDLE;
    end else begin
      target_q  <= target_d;
      current_q <= current_d;
      state_q   <= state_d;
    end
  end

  assign target  = target_q;
  assign current = current_q;
  assign busy    = (current_q != target_q);

endmodule

// File: rtl/soc_amp_ramp.sv
// Avalon-MM amplitude ramp controller: bus decode, STEP/CTRL/DONE, read mux.
module soc_amp_ramp
  import soc_amp_pkg::*;
#(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned STEP_RESET = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [3:0]                address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  input  logic                      sample_tick,
  output logic [CHANNELS*WIDTH-1:0] out_port,
  output logic                      irq
);

  logic                wr;
  logic [WIDTH-1:0]    step_q, step_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic [CHANNELS-1:0] done_set;
  logic [CHANNELS-1:0] busy;
  logic [WIDTH-1:0]    target_w  [CHANNELS];
  logic [WIDTH-1:0]    current_w [CHANNELS];
  logic                unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    soc_amp_ramp_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .target_we    (wr && (address == 4'(g))),
      .target_wdata (writedata[WIDTH-1:0]),
      .step         (step_q),
      .tick         (sample_tick),
      .bypass       (ctrl_q[CTRL_BYPASS]),
      .freeze       (ctrl_q[CTRL_FREEZE]),
      .target       (target_w[g]),
      .current      (current_w[g]),
      .busy         (busy[g]),
      .done_set     (done_set[g])
    );
    assign out_port[g*WIDTH +: WIDTH] = current_w[g];
  end

  // Register writes; a DONE set from a channel overrides a coincident clear.
  always_comb begin
    step_d = step_q;
    ctrl_d = ctrl_q;
    done_d = done_q;
    if (wr && address == ADDR_STEP) step_d = writedata[WIDTH-1:0];
    if (wr && address == ADDR_CTRL) ctrl_d = writedata[CTRL_W-1:0] & CTRL_MASK;
    if (wr && address == ADDR_DONE) done_d = done_q & ~writedata[CHANNELS-1:0];
    done_d = done_d | done_set;
  end

  // Control registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      step_q <= WIDTH'(STEP_RESET);
      ctrl_q <= '0;
      done_q <= '0;
    end else begin
      step_q <= step_d;
      ctrl_q <= ctrl_d;
      done_q <= done_d;
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    readdata = '0;
    if (!address[3]) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (address == 4'(i)) readdata = 32'(target_w[i]);
      end
    end else begin
      case (address)
        ADDR_STEP: readdata = 32'(step_q);
        ADDR_CTRL: readdata = 32'(ctrl_q);
        ADDR_BUSY: readdata = 32'(busy);
        ADDR_DONE: readdata = 32'(done_q);
        ADDR_CUR: begin
          for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (ctrl_q[CTRL_SEL_MSB:CTRL_SEL_LSB] == 3'(i)) readdata = 32'(current_w[i]);
          end
        end
        default: readdata = '0;
      endcase
    end
  end

  assign irq = ctrl_q[CTRL_IRQ_EN] & (|done_q);

endmodule

// File: tb/tb_soc_amp_ramp.sv
// Directed self-checking bench for soc_amp_ramp.
module tb_soc_amp_ramp;

  logic        clk;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        sample_tick;
  logic [63:0] out_port;
  logic        irq;

  int checks;
  int errors;

  soc_amp_ramp #(
    .CHANNELS   (4),
    .WIDTH      (16),
    .STEP_RESET (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .sample_tick (sample_tick),
    .out_port    (out_port),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called right after a negedge; no rising edge falls inside the #1 window.
  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    chk(tag, 64'(readdata), 64'(exp));
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b0;
    address     = '0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = '0;
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state: every address zero except STEP.
    for (int a = 0; a < 16; a++) begin
      rd($sformatf("reset_rd_%0h", a), 4'(a), (a == 8) ? 32'h1 : 32'h0);
    end
    chk("reset_out_port", out_port, 64'h0);
    chk("reset_irq", 64'(irq), 64'h0);

    // Channel 0 ramps up to 0x350 in steps of 0x100.
    wr(4'h8, 32'h100);
    wr(4'h0, 32'h0350);
    rd("c0_busy_start", 4'hA, 32'h1);
    tick(); rd("c0_t1", 4'hC, 32'h100);
    tick(); rd("c0_t2", 4'hC, 32'h200);
    tick(); rd("c0_t3", 4'hC, 32'h300);
    rd("c0_done_before", 4'hB, 32'h0);
    rd("c0_busy_before", 4'hA, 32'h1);
    tick(); rd("c0_t4", 4'hC, 32'h350);
    rd("c0_done_after", 4'hB, 32'h1);
    rd("c0_busy_after", 4'hA, 32'h0);
    chk("c0_out_port", 64'(out_port[15:0]), 64'h350);
    chk("c0_irq_disabled", 64'(irq), 64'h0);
    wr(4'hB, 32'h1);
    rd("c0_done_clr", 4'hB, 32'h0);

    // Channel 1 preloaded to 0x400 via bypass, then ramps down without wrap.
    wr(4'h9, 32'h1);
    wr(4'h1, 32'h0400);
    @(negedge clk);
    wr(4'h9, 32'h10);
    rd("c1_preload", 4'hC, 32'h400);
    rd("c1_bypass_done", 4'hB, 32'h2);
    wr(4'hB, 32'h2);
    wr(4'h8, 32'h300);
    wr(4'h1, 32'h0);
    tick(); rd("c1_t1", 4'hC, 32'h100);
    chk("c1_out_port_t1", 64'(out_port[31:16]), 64'h100);
    tick(); rd("c1_t2", 4'hC, 32'h0);
    rd("c1_done", 4'hB, 32'h2);
    wr(4'hB, 32'h2);

    // Freeze discards ticks; bypass then snaps to target.
    wr(4'h1, 32'h1000);
    tick(); rd("frz_start", 4'hC, 32'h300);
    wr(4'h9, 32'h12);
    tick(); tick(); tick();
    rd("frz_hold", 4'hC, 32'h300);
    rd("frz_no_done", 4'hB, 32'h0);
    wr(4'h9, 32'h11);
    @(negedge clk);
    rd("byp_snap", 4'hC, 32'h1000);
    rd("byp_done", 4'hB, 32'h2);
    wr(4'h9, 32'h10);
    wr(4'hB, 32'h2);

    // DONE set wins over a coincident write-1-to-clear.
    wr(4'h9, 32'h24);
    wr(4'h2, 32'h100);
    tick();
    rd("c2_t1", 4'hC, 32'h100);
    chk("c2_irq_set", 64'(irq), 64'h1);
    wr(4'h2, 32'h200);
    @(negedge clk);
    address     = 4'hB;
    writedata   = 32'h4;
    chipselect  = 1'b1;
    write_n     = 1'b0;
    sample_tick = 1'b1;
    @(negedge clk);
    chipselect  = 1'b0;
    write_n     = 1'b1;
    sample_tick = 1'b0;
    rd("c2_set_wins", 4'hB, 32'h4);
    chk("c2_irq_held", 64'(irq), 64'h1);
    wr(4'hB, 32'h4);
    rd("c2_cleared", 4'hB, 32'h0);
    chk("c2_irq_low", 64'(irq), 64'h0);

    // Reset mid-ramp with a tick and a write pending.
    wr(4'h0, 32'h2000);
    tick();
    chk("rst_pre_ramp", 64'(out_port[15:0]), 64'h650);
    @(negedge clk);
    reset_n     = 1'b0;
    sample_tick = 1'b1;
    address     = 4'h8;
    writedata   = 32'h55;
    chipselect  = 1'b1;
    write_n     = 1'b0;
    @(negedge clk);
    reset_n     = 1'b1;
    sample_tick = 1'b0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    chk("rst_out_port", out_port, 64'h0);
    rd("rst_done", 4'hB, 32'h0);
    rd("rst_step", 4'h8, 32'h1);
    rd("rst_target0", 4'h0, 32'h0);
    rd("rst_ctrl", 4'h9, 32'h0);
    rd("rst_busy", 4'hA, 32'h0);
    chk("rst_irq", 64'(irq), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
